multicycle_stage: RTL and testbench

//  Parametrised fixed-latency valid/ready stage carrying a DW-bit payload from input to output after exactly LAT

---
 rtl/multicycle_stage_if.sv | 22 ++
 rtl/multicycle_stage.sv | 135 +++++++++++++
 tb/tb_multicycle_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_stage_if.sv
// Valid/ready bus for multicycle_stage: upstream handshake plus downstream handshake.
// The stage side uses the slave modport and the bus owner (driver/sink) uses master.
interface multicycle_stage_if #(
  parameter int DW = 32
);
  logic          ival;
  logic [DW-1:0] idata;
  logic          irdy;
  logic          oval;
  logic [DW-1:0] odata;
  logic          ordy;

  modport slave (
    input  ival, idata, ordy,
    output irdy, oval, odata
  );

  modport master (
    output ival, idata, ordy,
    input  irdy, oval, odata
  );
endinterface

// File: rtl/multicycle_stage.sv
// Fixed-latency valid/ready stage: PIPE=0 holds one transaction for LAT cycles,
// PIPE=1 is a LAT-deep bubble-collapsing shift pipeline. Reports occupancy, supports flush.
module multicycle_stage #(
  parameter int DW   = 32,
  parameter int LAT  = 5,
  parameter int PIPE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  multicycle_stage_if.slave         io,
  output logic [$clog2(LAT+1)-1:0]  occ
);
  localparam int OCW = $clog2(LAT+1);

  logic          irdy;
  logic          oval;
  logic [DW-1:0] odata;
  logic          iack;
  logic          oack;
  logic [OCW-1:0] occ_q, occ_d;

  assign io.irdy  = irdy;
  assign io.oval  = oval;
  assign io.odata = odata;
  assign iack     = io.ival & irdy;
  assign oack     = oval & io.ordy;
  assign occ      = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (flush)
      occ_d = '0;
    else if (iack && !oack)
      occ_d = occ_q + OCW'(1);
    else if (oack && !iack)
      occ_d = occ_q - OCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  if (PIPE == 0) begin : g_blocking
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

    state_e         st_q, st_d;
    logic [OCW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]  data_q;

    assign oval  = (st_q == S_HOLD);
    assign irdy  = !flush && ((st_q == S_IDLE) || (oval && io.ordy));
    assign odata = data_q;

    // cnt mirrors the 1..LAT-1 phase of the transaction; S_HOLD stands for phase LAT.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (flush) begin
        st_d  = S_IDLE;
        cnt_d = '0;
      end else if (iack) begin
        st_d  = (LAT == 1) ? S_HOLD : S_RUN;
        cnt_d = OCW'(1);
      end else begin
        case (st_q)
          S_RUN: begin
            if (cnt_q == OCW'(LAT-1)) st_d = S_HOLD;
            else                      cnt_d = cnt_q + OCW'(1);
          end
          S_HOLD: begin
            if (io.ordy) st_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= S_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    data_q <= '0;
      else if (iack) data_q <= io.idata;
    end
  end else begin : g_pipelined
    logic [LAT-1:0] v_q;
    logic [LAT-1:0] free;
    logic [DW-1:0]  d_q [LAT];

    // free[k]: stage k may load this cycle (empty, or everything ahead of it moves).
    always_comb begin : free_chain
      logic f;
      free = '0;
      f = ~v_q[LAT-1] | io.ordy;
      free[LAT-1] = f;
      for (int unsigned k = 1; k < LAT; k++) begin
        f = ~v_q[LAT-1-k] | f;
        free[LAT-1-k] = f;
      end
    end

    assign irdy  = !flush && free[0];
    assign oval  = v_q[LAT-1];
    assign odata = d_q[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int unsigned k = 0; k < LAT; k++) d_q[k] <= '0;
      end else if (flush) begin
        v_q <= '0;
      end else begin
        if (free[0]) begin
          v_q[0] <= iack;
          if (iack) d_q[0] <= io.idata;
        end
        for (int unsigned k = 1; k < LAT; k++) begin
          if (free[k]) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_multicycle_stage.sv
// Drives four stage configurations (LAT 5/1 x PIPE 0/1) with shared stimulus and
// checks each against a queue model using accept times and departure times.
module tb_multicycle_stage;
  localparam int DW   = 16;
  localparam int NDUT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          ival = 1'b0;
  logic          ordy = 1'b0;
  logic [DW-1:0] idata = '0;

  logic          irdy_w  [NDUT];
  logic          oval_w  [NDUT];
  logic [DW-1:0] odata_w [NDUT];
  logic [31:0]   occ_w   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gd
    localparam int GLAT = (g < 2) ? 5 : 1;
    logic [$clog2(GLAT+1)-1:0] occ_l;
    multicycle_stage_if #(.DW(DW)) bus ();
    assign bus.ival  = ival;
    assign bus.idata = idata;
    assign bus.ordy  = ordy;
    multicycle_stage #(.DW(DW), .LAT(GLAT), .PIPE(g % 2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .io    (bus),
      .occ   (occ_l)
    );
    assign irdy_w[g]  = bus.irdy;
    assign oval_w[g]  = bus.oval;
    assign odata_w[g] = bus.odata;
    assign occ_w[g]   = 32'(occ_l);
  end

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] mq_d [NDUT][$];
  int            mq_a [NDUT][$];
  int            last_leave [NDUT];

  function automatic int lat_of(int i);
    return (i < 2) ? 5 : 1;
  endfunction

  function automatic int pipe_of(int i);
    return i % 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear(input int i);
    mq_d[i].delete();
    mq_a[i].delete();
    last_leave[i] = -1000;
  endtask

  // One clock cycle: drive inputs, compare every DUT against its model, advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    @(negedge clk);
    ival = v; idata = d; ordy = r; flush = f;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      int n;
      int vis;
      bit mo, mr, ia, oa;
      n  = mq_d[i].size();
      mo = 1'b0;
      if (n > 0) begin
        // head is visible LAT cycles after acceptance, but never before its predecessor left
        vis = mq_a[i][0] + lat_of(i);
        if (last_leave[i] + 1 > vis) vis = last_leave[i] + 1;
        mo = (cyc >= vis);
      end
      if (pipe_of(i) == 0) mr = !f && (n == 0 || (mo && r));
      else                 mr = !f && (n < lat_of(i) || r);
      chk($sformatf("irdy[%0d]", i), 32'(irdy_w[i]), 32'(mr));
      chk($sformatf("oval[%0d]", i), 32'(oval_w[i]), 32'(mo));
      chk($sformatf("occ[%0d]", i), occ_w[i], 32'(n));
      if (mo) chk($sformatf("odata[%0d]", i), 32'(odata_w[i]), 32'(mq_d[i][0]));
      ia = v && mr;
      oa = mo && r;
      if (oa) begin
        void'(mq_d[i].pop_front());
        void'(mq_a[i].pop_front());
        last_leave[i] = cyc;
      end
      if (ia) begin
        mq_d[i].push_back(d);
        mq_a[i].push_back(cyc);
      end
      if (f) model_clear(i);
    end
    cyc++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ival = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_oval[%0d]", i), 32'(oval_w[i]), 32'd0);
      chk($sformatf("rst_occ[%0d]", i), occ_w[i], 32'd0);
      chk($sformatf("rst_odata[%0d]", i), 32'(odata_w[i]), 32'd0);
      chk($sformatf("rst_irdy[%0d]", i), 32'(irdy_w[i]), 32'd1);
      model_clear(i);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) model_clear(i);
    pulse_reset();

    // T1: single transaction through the blocking LAT=5 stage
    step(1'b1, 16'h00A5, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t1_irdy_low", 32'(irdy_w[0]), 32'd0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_oval", 32'(oval_w[0]), 32'd1);
    chk("t1_odata", 32'(odata_w[0]), 32'h00A5);
    drain();

    // T2/T3: continuous input, downstream always ready
    for (int k = 0; k < 30; k++) step(1'b1, DW'(k), 1'b1, 1'b0);
    chk("t2_occ", occ_w[0], 32'd1);
    chk("t3_occ", occ_w[1], 32'd5);
    drain();

    // T4: downstream stalled, pipeline fills to LAT then blocks
    for (int k = 0; k < 10; k++) step(1'b1, DW'(k), 1'b0, 1'b0);
    chk("t4_occ", occ_w[1], 32'd5);
    chk("t4_irdy", 32'(irdy_w[1]), 32'd0);
    chk("t4_odata", 32'(odata_w[1]), 32'd0);
    drain();

    // T5: flush with three in flight
    for (int k = 0; k < 3; k++) step(1'b1, DW'(16'h100 + k), 1'b0, 1'b0);
    step(1'b1, 16'h1FF, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t5_oval", 32'(oval_w[1]), 32'd0);
    chk("t5_occ", occ_w[1], 32'd0);
    chk("t5_irdy", 32'(irdy_w[1]), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b1, DW'(16'h200 + k), 1'b1, 1'b0);
    drain();

    // T6: asynchronous reset mid-operation
    for (int k = 0; k < 4; k++) step(1'b1, DW'(16'h300 + k), 1'b0, 1'b0);
    pulse_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_oval", 32'(oval_w[1]), 32'd0);
    chk("t6_occ", occ_w[1], 32'd0);
    chk("t6_irdy", 32'(irdy_w[0]), 32'd1);

    // Random traffic with occasional flush
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, DW'($urandom),
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
